// File: rtl/variable_flip_table_pkg.sv
// Shared types and defaults for the variable flip table.
package variable_flip_table_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } vft_state_e;

   localparam int DEF_VARIABLE_ADDRESS_WIDTH = 11;
   localparam int DEF_NUM_READ_PORTS         = 40;
   localparam int DEF_FLIP_FIFO_DEPTH        = 4;
   localparam int FLIP_COUNT_W               = 16;

endpackage

// File: rtl/variable_flip_table_fifo.sv
// Synchronous queue of pending flip addresses with valid/ready push and level.
module flip_request_fifo
   import variable_flip_table_pkg::*;
#(
   parameter int DEPTH  = DEF_FLIP_FIFO_DEPTH,
   parameter int DATA_W = DEF_VARIABLE_ADDRESS_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_valid_i,
   output logic                     push_ready_o,
   input  logic [DATA_W-1:0]        push_data_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        pop_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    level_q, level_d;
   logic              push;
   logic              pop;

   assign push_ready_o = (level_q != (PTR_W+1)'(DEPTH));
   assign empty_o      = (level_q == '0);
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign level_o      = level_q;
   assign push         = push_valid_i && push_ready_o;
   assign pop          = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         level_d = level_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         level_d = level_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/variable_flip_table.sv
// Bit table with many read ports, an AXI-style access port and a queued toggle path.
//   state    | meaning
//   ST_CLEAR | sweeping zeros through every address, flips and AXI writes blocked
//   ST_RUN   | normal operation, AXI writes and queued flips applied
module variable_flip_table
   import variable_flip_table_pkg::*;
#(
   parameter int VARIABLE_ADDRESS_WIDTH = DEF_VARIABLE_ADDRESS_WIDTH,
   parameter int NUM_READ_PORTS         = DEF_NUM_READ_PORTS,
   parameter int FLIP_FIFO_DEPTH        = DEF_FLIP_FIFO_DEPTH
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       axi_en_i,
   input  logic                                       axi_wr_en_i,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0]          axi_addr_i,
   input  logic                                       axi_data_i,
   output logic                                       axi_data_o,
   input  logic                                       rd_en_i,
   input  logic [NUM_READ_PORTS*VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_mi,
   output logic [NUM_READ_PORTS-1:0]                  rd_data_mo,
   input  logic                                       flip_valid_i,
   output logic                                       flip_ready_o,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0]          flip_addr_i,
   output logic                                       busy_o,
   output logic [$clog2(FLIP_FIFO_DEPTH):0]           fifo_level_o,
   output logic [FLIP_COUNT_W-1:0]                    flip_count_o
);

   localparam int AW    = VARIABLE_ADDRESS_WIDTH;
   localparam int DEPTH = 1 << AW;

   vft_state_e              state_q;
   logic                    busy_q;
   logic [AW-1:0]           clr_addr_q;
   logic [DEPTH-1:0]        table_q, table_d;
   logic [NUM_READ_PORTS-1:0] rd_data_q, rd_data_d;
   logic                    axi_data_q, axi_data_d;
   logic [FLIP_COUNT_W-1:0] count_q, count_d;
   logic                    axi_wr;
   logic                    pop;
   logic                    fifo_push_ready;
   logic                    fifo_empty;
   logic [AW-1:0]           fifo_head;

   assign axi_wr = axi_en_i && axi_wr_en_i;
   // An AXI write steals the table write slot, so the head stays queued.
   assign pop    = rst_ni && (state_q == ST_RUN) && !fifo_empty && !axi_wr;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_addr_q <= clr_addr_q + AW'(1);
               if (clr_addr_q == '1) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q <= ST_CLEAR;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   flip_request_fifo #(
      .DEPTH  (FLIP_FIFO_DEPTH),
      .DATA_W (AW)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_valid_i (flip_valid_i && (state_q == ST_RUN)),
      .push_ready_o (fifo_push_ready),
      .push_data_i  (flip_addr_i),
      .pop_i        (pop),
      .pop_data_o   (fifo_head),
      .empty_o      (fifo_empty),
      .level_o      (fifo_level_o)
   );

   always_comb begin
      table_d = table_q;
      if (rst_ni) begin
         if (state_q == ST_CLEAR) begin
            table_d[clr_addr_q] = 1'b0;
         end else if (axi_wr) begin
            table_d[axi_addr_i] = axi_data_i;
         end else if (pop) begin
            table_d[fifo_head] = ~table_q[fifo_head];
         end
      end
   end

   // Reads sample table_q, so same-edge writes and flips are seen next cycle.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         for (int k = 0; k < NUM_READ_PORTS; k++) begin
            rd_data_d[k] = table_q[rd_addr_mi[k*AW +: AW]];
         end
      end
   end

   always_comb begin
      axi_data_d = axi_data_q;
      if (axi_en_i && !axi_wr_en_i) begin
         axi_data_d = table_q[axi_addr_i];
      end
   end

   always_comb begin
      count_d = count_q;
      if (pop && (count_q != '1)) begin
         count_d = count_q + FLIP_COUNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_data_q  <= '0;
         axi_data_q <= 1'b0;
         count_q    <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         axi_data_q <= axi_data_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      table_q <= table_d;
   end

   assign busy_o       = busy_q;
   assign flip_ready_o = (state_q == ST_RUN) && fifo_push_ready;
   assign rd_data_mo   = rd_data_q;
   assign axi_data_o   = axi_data_q;
   assign flip_count_o = count_q;

endmodule

// File: tb/tb_variable_flip_table.sv
// Bench for variable_flip_table: queue/array reference model plus directed literal checks.
module tb_variable_flip_table;

   localparam int AW    = 11;
   localparam int NP    = 40;
   localparam int FD    = 4;
   localparam int DEPTH = 2048;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             axi_en_i, axi_wr_en_i, axi_data_i;
   logic [AW-1:0]    axi_addr_i;
   logic             axi_data_o;
   logic             rd_en_i;
   logic [NP*AW-1:0] rd_addr_mi;
   logic [NP-1:0]    rd_data_mo;
   logic             flip_valid_i, flip_ready_o;
   logic [AW-1:0]    flip_addr_i;
   logic             busy_o;
   logic [2:0]       fifo_level_o;
   logic [15:0]      flip_count_o;

   always #5 clk = ~clk;

   variable_flip_table #(
      .VARIABLE_ADDRESS_WIDTH (AW),
      .NUM_READ_PORTS         (NP),
      .FLIP_FIFO_DEPTH        (FD)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .axi_en_i     (axi_en_i),
      .axi_wr_en_i  (axi_wr_en_i),
      .axi_addr_i   (axi_addr_i),
      .axi_data_i   (axi_data_i),
      .axi_data_o   (axi_data_o),
      .rd_en_i      (rd_en_i),
      .rd_addr_mi   (rd_addr_mi),
      .rd_data_mo   (rd_data_mo),
      .flip_valid_i (flip_valid_i),
      .flip_ready_o (flip_ready_o),
      .flip_addr_i  (flip_addr_i),
      .busy_o       (busy_o),
      .fifo_level_o (fifo_level_o),
      .flip_count_o (flip_count_o)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain arrays and a queue, updated once per clock edge.
   bit          m_tab   [DEPTH];
   bit          m_known [DEPTH];
   bit          m_clear     = 1'b1;
   int          m_clr_idx   = 0;
   int unsigned m_q[$];
   int          m_count     = 0;
   logic [NP-1:0] m_rd      = '0;
   logic [NP-1:0] m_rd_known = '1;
   bit          m_axi       = 1'b0;
   bit          m_axi_known = 1'b1;
   int          m_a;
   bit          m_ready;

   always @(posedge clk) begin
      if (!rst_ni) begin
         m_clear     = 1'b1;
         m_clr_idx   = 0;
         m_q.delete();
         m_count     = 0;
         m_rd        = '0;
         m_rd_known  = '1;
         m_axi       = 1'b0;
         m_axi_known = 1'b1;
      end else begin
         if (rd_en_i) begin
            for (int k = 0; k < NP; k++) begin
               m_a = int'(rd_addr_mi[k*AW +: AW]);
               m_rd[k]       = m_tab[m_a];
               m_rd_known[k] = m_known[m_a];
            end
         end
         if (axi_en_i && !axi_wr_en_i) begin
            m_axi       = m_tab[int'(axi_addr_i)];
            m_axi_known = m_known[int'(axi_addr_i)];
         end
         m_ready = !m_clear && (m_q.size() < FD);
         if (m_clear) begin
            m_tab[m_clr_idx]   = 1'b0;
            m_known[m_clr_idx] = 1'b1;
            m_clr_idx++;
            if (m_clr_idx == DEPTH) m_clear = 1'b0;
         end else if (axi_en_i && axi_wr_en_i) begin
            m_tab[int'(axi_addr_i)]   = axi_data_i;
            m_known[int'(axi_addr_i)] = 1'b1;
         end else if (m_q.size() > 0) begin
            m_a = int'(m_q.pop_front());
            m_tab[m_a] = !m_tab[m_a];
            if (m_count < 65535) m_count++;
         end
         if (flip_valid_i && m_ready) m_q.push_back(int'(flip_addr_i));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",  busy_o,       m_clear);
         chk("ready", flip_ready_o, !m_clear && (m_q.size() < FD));
         chk("level", fifo_level_o, m_q.size());
         chk("count", flip_count_o, m_count);
         if (m_axi_known) chk("axi_data", axi_data_o, m_axi);
         chk("rd_data", rd_data_mo & m_rd_known, m_rd & m_rd_known);
      end
   end

   task automatic idle();
      axi_en_i     = 1'b0;
      axi_wr_en_i  = 1'b0;
      axi_addr_i   = '0;
      axi_data_i   = 1'b0;
      rd_en_i      = 1'b0;
      rd_addr_mi   = '0;
      flip_valid_i = 1'b0;
      flip_addr_i  = '0;
   endtask

   task automatic set_all_rd(input logic [AW-1:0] a);
      for (int k = 0; k < NP; k++) rd_addr_mi[k*AW +: AW] = a;
   endtask

   task automatic randomize_inputs(input int addr_max);
      axi_en_i     = ($urandom_range(0, 3) == 0);
      axi_wr_en_i  = 1'($urandom_range(0, 1));
      axi_addr_i   = AW'($urandom_range(0, 31));
      axi_data_i   = 1'($urandom_range(0, 1));
      flip_valid_i = 1'($urandom_range(0, 1));
      flip_addr_i  = AW'($urandom_range(0, 31));
      rd_en_i      = 1'($urandom_range(0, 1));
      for (int k = 0; k < NP; k++) rd_addr_mi[k*AW +: AW] = AW'($urandom_range(0, addr_max));
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic d);
      axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = a; axi_data_i = d;
      @(negedge clk);
      axi_en_i = 1'b0; axi_wr_en_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   int cnt, idx, acc;
   bit take;

   initial begin
      idle();
      rst_ni = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy",  busy_o,       1);
      chk("rst_ready", flip_ready_o, 0);
      chk("rst_level", fifo_level_o, 0);
      chk("rst_count", flip_count_o, 0);
      chk("rst_rd",    rd_data_mo,   0);
      chk("rst_axi",   axi_data_o,   0);

      // Sweep with random traffic; writes and flips must be ignored meanwhile.
      rst_ni = 1'b1;
      cnt = 0;
      while (busy_o === 1'b1 && cnt < 3000) begin
         randomize_inputs(DEPTH - 1);
         cnt++;
         @(negedge clk);
      end
      idle();
      chk("busy_cycles", cnt, 2048);

      set_all_rd(11'h7FF); rd_en_i = 1'b1;
      @(negedge clk); rd_en_i = 1'b0;
      chk("sweep_7ff", rd_data_mo, 40'h0);

      axi_write(11'h005, 1'b1);
      set_all_rd(11'h005); rd_en_i = 1'b1;
      @(negedge clk); rd_en_i = 1'b0;
      chk("wr5_rd", rd_data_mo, {40{1'b1}});
      axi_en_i = 1'b1; axi_wr_en_i = 1'b0; axi_addr_i = 11'h005;
      @(negedge clk); axi_en_i = 1'b0;
      chk("wr5_axi", axi_data_o, 1);

      flip_valid_i = 1'b1; flip_addr_i = 11'h00A; @(negedge clk);
      flip_addr_i = 11'h00A;                      @(negedge clk);
      flip_addr_i = 11'h00B;                      @(negedge clk);
      flip_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      rd_addr_mi[0 +: AW] = 11'h00A; rd_addr_mi[AW +: AW] = 11'h00B; rd_en_i = 1'b1;
      @(negedge clk); rd_en_i = 1'b0;
      chk("dup_0a", rd_data_mo[0], 0);
      chk("dup_0b", rd_data_mo[1], 1);
      chk("dup_count", flip_count_o, 3);

      // Held AXI write starves pops so the queue fills.
      axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 11'h020; axi_data_i = 1'b1;
      idx = 0; acc = 0;
      for (int c = 0; c < 6; c++) begin
         flip_valid_i = (idx < 5);
         flip_addr_i  = AW'(11'h030 + idx);
         take = flip_valid_i && flip_ready_o;
         if (take) acc++;
         @(negedge clk);
         if (take) idx++;
      end
      chk("stall_accepted", acc, 4);
      chk("stall_level", fifo_level_o, 4);
      chk("stall_ready", flip_ready_o, 0);
      axi_en_i = 1'b0; axi_wr_en_i = 1'b0;
      @(negedge clk);
      chk("pop_resume", fifo_level_o, 3);
      @(negedge clk);
      chk("push_pop_level", fifo_level_o, 3);
      flip_valid_i = 1'b0;
      repeat (6) @(negedge clk);
      rd_addr_mi[0 +: AW] = 11'h020;
      for (int k = 1; k < 6; k++) rd_addr_mi[k*AW +: AW] = AW'(11'h030 + k - 1);
      rd_en_i = 1'b1;
      @(negedge clk); rd_en_i = 1'b0;
      chk("drain_vals", rd_data_mo[5:0], 6'h3F);
      chk("drain_count", flip_count_o, 8);

      axi_write(11'h003, 1'b1);
      flip_valid_i = 1'b1; flip_addr_i = 11'h003;
      @(negedge clk); flip_valid_i = 1'b0;
      set_all_rd(11'h003); rd_en_i = 1'b1;
      @(negedge clk);
      chk("same_cycle_old", rd_data_mo[0], 1);
      @(negedge clk); rd_en_i = 1'b0;
      chk("after_flip", rd_data_mo[0], 0);

      for (int c = 0; c < 1500; c++) begin
         randomize_inputs(31);
         @(negedge clk);
      end
      idle();
      repeat (8) @(negedge clk);

      axi_write(11'h7FE, 1'b1);
      axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 11'h040; axi_data_i = 1'b0;
      flip_valid_i = 1'b1; flip_addr_i = 11'h050; @(negedge clk);
      flip_addr_i = 11'h051;                      @(negedge clk);
      flip_addr_i = 11'h052;                      @(negedge clk);
      flip_valid_i = 1'b0;
      chk("pre_rst_level", fifo_level_o, 3);
      rst_ni = 1'b0; axi_en_i = 1'b0; axi_wr_en_i = 1'b0;
      @(negedge clk);
      chk("mid_rst_level", fifo_level_o, 0);
      chk("mid_rst_count", flip_count_o, 0);
      chk("mid_rst_busy",  busy_o,       1);
      chk("mid_rst_ready", flip_ready_o, 0);
      repeat (2) @(negedge clk);

      rst_ni = 1'b1;
      cnt = 0;
      while (busy_o === 1'b1 && cnt < 3000) begin
         if (cnt == 2) begin
            chk("restart_addr0", rd_data_mo[0], 0);
            chk("restart_7fe",   rd_data_mo[1], 1);
         end
         rd_en_i = (cnt == 1);
         rd_addr_mi[0 +: AW] = 11'h000; rd_addr_mi[AW +: AW] = 11'h7FE;
         cnt++;
         @(negedge clk);
      end
      idle();
      chk("restart_busy_cycles", cnt, 2048);
      set_all_rd(11'h7FE); rd_en_i = 1'b1;
      @(negedge clk); rd_en_i = 1'b0;
      chk("restart_cleared", rd_data_mo, 40'h0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
